// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the uart_rx / uart_tx pair: frame
//               geometry, FSM state encoding and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Payload bits per frame (8N1)
   localparam int DATA_BITS = 8;

   // Bit index counter width covering 0 .. DATA_BITS-1
   localparam int IDX_W = $clog2(DATA_BITS);

   // Frame sequencing states shared by receiver and transmitter
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } uart_state_t;

   // Clock counter width; one spare bit keeps CLKS_PER_BIT itself representable
   function automatic int cnt_width(input int clks_per_bit);
      return $clog2(clks_per_bit) + 1;
   endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit with a
//               configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [1:0] ff;

   // Shift the asynchronous input through two flops to settle metastability
   always_ff @(posedge clk) begin
      if (reset) begin
         ff <= {2{RESET_VAL}};
      end else begin
         ff <= {ff[0], d};
      end
   end

   assign q = ff[1];

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter. Latches a byte on uart_tx_start while
//               idle and shifts out start, 8 data bits LSB first and stop,
//               each held CLKS_PER_BIT clocks. Starts while busy are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 uart_tx_start,
   input  logic [DATA_BITS-1:0] uart_tx_input,
   output logic                 uart_txd
);

   localparam int                CNT_W    = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

   uart_state_t            state;
   logic [CNT_W-1:0]       clk_cnt;
   logic [IDX_W-1:0]       bit_idx;
   logic [DATA_BITS-1:0]   shreg;

   // Frame sequencer; uart_txd is registered so the line never glitches
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         uart_txd <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               uart_txd <= 1'b1;
               clk_cnt  <= '0;
               if (uart_tx_start) begin
                  shreg    <= uart_tx_input;
                  uart_txd <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt  <= '0;
                  bit_idx  <= '0;
                  uart_txd <= shreg[0];
                  shreg    <= shreg >> 1;
                  state    <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  if (bit_idx == IDX_LAST) begin
                     uart_txd <= 1'b1;
                     state    <= STOP;
                  end else begin
                     bit_idx  <= bit_idx + 1'b1;
                     uart_txd <= shreg[0];
                     shreg    <= shreg >> 1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               uart_txd <= 1'b1;
               clk_cnt  <= '0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule : uart_tx
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Synchronizes the serial line, validates the
//               start bit at mid-bit, samples 8 data bits LSB first and the
//               stop bit at mid-bit, then strobes uart_valid or uart_err.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 uart_rxd,
   output logic [DATA_BITS-1:0] uart_rx_data,
   output logic                 uart_err,
   output logic                 uart_valid
);

   localparam int                CNT_W     = cnt_width(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                   rxs;
   uart_state_t            state;
   logic [CNT_W-1:0]       clk_cnt;
   logic [IDX_W-1:0]       bit_idx;
   logic [DATA_BITS-1:0]   shreg;

   // Line idles high, so the synchronizer presets to 1 to avoid a false start
   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (uart_rxd),
      .q     (rxs)
   );

   // Receive sequencer with registered strobes; a partial byte stays in shreg
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         clk_cnt      <= '0;
         bit_idx      <= '0;
         shreg        <= '0;
         uart_rx_data <= '0;
         uart_valid   <= 1'b0;
         uart_err     <= 1'b0;
      end else begin
         uart_valid <= 1'b0;
         uart_err   <= 1'b0;
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               if (!rxs) begin
                  state <= START;
               end
            end
            START: begin
               // Re-check the line half a bit in to reject short glitches
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rxs ? IDLE : DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt         <= '0;
                  shreg[bit_idx]  <= rxs;
                  if (bit_idx == IDX_LAST) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  if (rxs) begin
                     uart_rx_data <= shreg;
                     uart_valid   <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     uart_err <= 1'b1;
                     state    <= WAIT_IDLE;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            WAIT_IDLE: begin
               // A held-low line (break) must return high before a new start
               clk_cnt <= '0;
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: begin
               clk_cnt <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx, with uart_tx as a
//               loopback source and a bench-driven line for fault cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
   import uart_pkg::*;

   localparam int CLKS_PER_BIT = 20;

   logic       clk;
   logic       reset;
   logic       use_tx;
   logic       line;
   logic       tx_start;
   logic [7:0] tx_input;
   logic       txd;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_err;
   logic       rx_valid;

   int errors;
   int checks;
   int valid_cnt;
   int err_cnt;
   int both_cnt;
   logic [7:0] rx_q[$];

   assign rxd = use_tx ? txd : line;

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk           (clk),
      .reset         (reset),
      .uart_tx_start (tx_start),
      .uart_tx_input (tx_input),
      .uart_txd      (txd)
   );

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
      .clk          (clk),
      .reset        (reset),
      .uart_rxd     (rxd),
      .uart_rx_data (rx_data),
      .uart_err     (rx_err),
      .uart_valid   (rx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor sampled on the falling edge
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt <= valid_cnt + 1;
         rx_q.push_back(rx_data);
      end
      if (rx_err) err_cnt <= err_cnt + 1;
      if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tx_send(input logic [7:0] b);
      @(negedge clk);
      tx_input = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic drive_bit(input logic b);
      line = b;
      cycles(CLKS_PER_BIT);
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   // Waits for uart_valid, returning the number of falling edges waited
   task automatic wait_valid(input int budget, output int lat, output bit found);
      found = 1'b0;
      lat   = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (rx_valid) begin
            found = 1'b1;
            lat   = c;
            break;
         end
      end
   endtask

   initial begin
      int  v0, e0, q0, lat;
      bit  found;
      errors    = 0;
      checks    = 0;
      valid_cnt = 0;
      err_cnt   = 0;
      both_cnt  = 0;
      reset     = 1'b1;
      use_tx    = 1'b0;
      line      = 1'b1;
      tx_start  = 1'b0;
      tx_input  = 8'h00;

      // Reset state
      cycles(100);
      check("rst_data",  rx_data,  8'h00);
      check("rst_valid", rx_valid, 1'b0);
      check("rst_err",   rx_err,   1'b0);
      check("rst_txd",   txd,      1'b1);
      reset = 1'b0;
      cycles(10);

      // Loopback 0x34: valid ~193 clocks after the start edge
      use_tx = 1'b1;
      v0 = valid_cnt;
      tx_send(8'h34);
      wait_valid(400, lat, found);
      check("lb34_found", found, 1'b1);
      check("lb34_data",  rx_data, 8'h34);
      check("lb34_err",   rx_err, 1'b0);
      check("lb34_lat_ok", (lat >= 190 && lat <= 196), 1'b1);
      cycles(30);
      check("lb34_one_pulse", valid_cnt - v0, 1);

      // Second frame 0x55 after a long idle, then 0xA3 back-to-back
      cycles(350);
      q0 = rx_q.size();
      tx_send(8'h55);
      cycles(199);
      tx_send(8'hA3);
      cycles(230);
      check("b2b_count", rx_q.size() - q0, 2);
      if (rx_q.size() >= q0 + 2) begin
         check("b2b_first",  rx_q[q0],     8'h55);
         check("b2b_second", rx_q[q0 + 1], 8'hA3);
      end else begin
         check("b2b_bytes_present", rx_q.size(), q0 + 2);
      end
      check("b2b_data", rx_data, 8'hA3);

      // Framing error: stop bit low and line held low for 3 more bit times
      use_tx = 1'b0;
      line   = 1'b1;
      cycles(40);
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_frame(8'hA5, 1'b0);
      cycles(3 * CLKS_PER_BIT);
      check("ferr_err_pulse", err_cnt - e0, 1);
      check("ferr_no_valid",  valid_cnt - v0, 0);
      check("ferr_data_kept", rx_data, 8'hA3);
      line = 1'b1;
      cycles(2 * CLKS_PER_BIT);
      check("ferr_quiet_err", err_cnt - e0, 1);
      v0 = valid_cnt;
      drive_frame(8'h0F, 1'b1);
      cycles(20);
      check("after_ferr_valid", valid_cnt - v0, 1);
      check("after_ferr_data",  rx_data, 8'h0F);
      check("after_ferr_err",   err_cnt - e0, 1);

      // Glitch shorter than half a bit
      v0 = valid_cnt;
      e0 = err_cnt;
      line = 1'b0;
      cycles(5);
      line = 1'b1;
      cycles(30);
      check("glitch_no_valid", valid_cnt - v0, 0);
      check("glitch_no_err",   err_cnt - e0, 0);
      check("glitch_idle",     dut.state, IDLE);

      // Reset during bit 4 of 0xFF
      cycles(10);
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_bit(1'b0);
      line = 1'b1;
      cycles(4 * CLKS_PER_BIT + 10);
      reset = 1'b1;
      cycles(3);
      check("midrst_data",  rx_data,  8'h00);
      check("midrst_valid", rx_valid, 1'b0);
      check("midrst_err",   rx_err,   1'b0);
      reset = 1'b0;
      cycles(150);
      check("midrst_no_strobe", (valid_cnt - v0) + (err_cnt - e0), 0);
      drive_frame(8'hFF, 1'b1);
      cycles(20);
      check("post_rst_valid", valid_cnt - v0, 1);
      check("post_rst_data",  rx_data, 8'hFF);

      check("never_both", both_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute run-time guard
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_uart_rx
`default_nettype wire
